// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the digit-serial comparator
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmpState_t;

  localparam logic CMP_UNSIGNED = 1'b0;
  localparam logic CMP_SIGNED   = 1'b1;

  // Digit index width; a single-digit compare still needs a 1-bit counter.
  function automatic int idxWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - DIGIT-bit ripple slice computing a_d + ~b_d + cin
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] carryChain;

  assign carryChain[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : gBit
    full_adder uFa (
      .a    (a_d[i]),
      .b    (~b_d[i]),
      .cin  (carryChain[i]),
      .sum  (sum[i]),
      .cout (carryChain[i+1])
    );
  end

  assign cout  = carryChain[DIGIT];
  // Carry into the slice MSB; only meaningful on the top digit for overflow.
  assign c_msb = carryChain[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - digit-serial signed/unsigned magnitude comparator
module seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic [WIDTH-1:0] diff,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = idxWidth(NDIG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  cmpState_t        state, stateNext;
  logic [WIDTH-1:0] aSh, bSh, diffSh, diffNext;
  logic [IW-1:0]    idx;
  logic             carry, zeroAcc, modeSigned;
  logic [DIGIT-1:0] sumD;
  logic             coutD, cMsbD;
  logic             accept, lastDigit;
  logic             eqFin, ovfFin, ltFin, gtFin;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign lastDigit = (state == RUN) && (idx == LAST_IDX);

  addsub_digit #(.DIGIT(DIGIT)) uSlice (
    .a_d   (aSh[DIGIT-1:0]),
    .b_d   (bSh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (sumD),
    .cout  (coutD),
    .c_msb (cMsbD)
  );

  if (NDIG == 1) begin : gOneDigit
    assign diffNext = sumD;
  end else begin : gManyDigit
    assign diffNext = {sumD, diffSh[WIDTH-1:DIGIT]};
  end

  // Final-digit view of the result, registered only on the last RUN edge.
  assign eqFin  = zeroAcc & (sumD == '0);
  assign ovfFin = cMsbD ^ coutD;
  assign ltFin  = (modeSigned == CMP_SIGNED) ? (diffNext[WIDTH-1] ^ ovfFin) : ~coutD;
  assign gtFin  = ~ltFin & ~eqFin;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (lastDigit) stateNext = DONE;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aSh        <= '0;
      bSh        <= '0;
      diffSh     <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      zeroAcc    <= 1'b0;
      modeSigned <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      a_eq_b     <= 1'b0;
      a_gt_b     <= 1'b0;
      a_lt_b     <= 1'b0;
      diff       <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        aSh        <= a;
        bSh        <= b;
        modeSigned <= is_signed;
        carry      <= 1'b1;
        idx        <= '0;
        zeroAcc    <= 1'b1;
        busy       <= 1'b1;
        a_eq_b     <= 1'b0;
        a_gt_b     <= 1'b0;
        a_lt_b     <= 1'b0;
      end else if (state == RUN) begin
        aSh     <= aSh >> DIGIT;
        bSh     <= bSh >> DIGIT;
        diffSh  <= diffNext;
        carry   <= coutD;
        zeroAcc <= eqFin;
        idx     <= idx + IW'(1);
        if (lastDigit) begin
          diff   <= diffNext;
          ovf    <= ovfFin;
          a_eq_b <= eqFin;
          a_gt_b <= gtFin;
          a_lt_b <= ltFin;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// tb/tb_seq_comparator.sv - directed self-checking bench for seq_comparator
module tb_seq_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, is_signed;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, a_eq_b, a_gt_b, a_lt_b, ovf;
  logic [WIDTH-1:0] diff;

  int compared   = 0;
  int mismatched = 0;
  int lat, busyCyc;
  logic sawDone;

  always #5 clk = ~clk;

  seq_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .a_eq_b    (a_eq_b),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .diff      (diff),
    .ovf       (ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic s);
    a = av;
    b = bv;
    is_signed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int busyCount);
    cycles = 0;
    busyCount = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busyCount++;
      tick();
      cycles++;
    end
  endtask

  task automatic checkResult(input string tag, input logic eq, input logic gt, input logic lt,
                             input logic [WIDTH-1:0] dv, input logic ov);
    check({tag, "_done"}, 32'(done), 32'(1'b1));
    check({tag, "_eq"}, 32'(a_eq_b), 32'(eq));
    check({tag, "_gt"}, 32'(a_gt_b), 32'(gt));
    check({tag, "_lt"}, 32'(a_lt_b), 32'(lt));
    check({tag, "_diff"}, 32'(diff), 32'(dv));
    check({tag, "_ovf"}, 32'(ovf), 32'(ov));
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(1'b0));
    check({tag, "_done"}, 32'(done), 32'(1'b0));
    check({tag, "_flags"}, 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(3'b000));
    check({tag, "_diff"}, 32'(diff), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'(1'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    checkIdle("reset");
    rst_n = 1'b1;
    tick();

    // Equal operands: latency and busy width.
    launch(16'h1234, 16'h1234, 1'b0);
    check("t1_busy_after_start", 32'(busy), 32'(1'b1));
    waitDone(lat, busyCyc);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_busy_cycles", 32'(busyCyc), 32'd4);
    checkResult("t1", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();

    launch(16'h0001, 16'hFFFF, 1'b0);
    waitDone(lat, busyCyc);
    checkResult("t2u", 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    tick();
    launch(16'h0001, 16'hFFFF, 1'b1);
    check("t2s_flags_cleared", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(3'b000));
    check("t2s_diff_held", 32'(diff), 32'h0002);
    waitDone(lat, busyCyc);
    checkResult("t2s", 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0);
    tick();

    launch(16'h7FFF, 16'h8000, 1'b1);
    waitDone(lat, busyCyc);
    checkResult("t3s", 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    tick();
    launch(16'h7FFF, 16'h8000, 1'b0);
    waitDone(lat, busyCyc);
    checkResult("t3u", 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    tick();

    launch(16'h8000, 16'h0001, 1'b1);
    waitDone(lat, busyCyc);
    checkResult("t4s", 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    tick();

    // Start and operand changes during RUN must be ignored.
    launch(16'h0005, 16'h0003, 1'b0);
    tick();
    a = 16'h0100;
    b = 16'h0200;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(lat, busyCyc);
    check("t5_ignore_latency", 32'(lat), 32'd2);
    checkResult("t5_ignore", 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0);

    // Back-to-back: start accepted on the DONE cycle.
    a = 16'h0003;
    b = 16'h0009;
    is_signed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_b2b_busy", 32'(busy), 32'(1'b1));
    check("t5_b2b_done_low", 32'(done), 32'(1'b0));
    check("t5_b2b_flags_cleared", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(3'b000));
    waitDone(lat, busyCyc);
    check("t5_b2b_latency", 32'(lat), 32'd4);
    checkResult("t5_b2b", 1'b0, 1'b0, 1'b1, 16'hFFFA, 1'b0);
    tick();
    tick();
    check("t5_hold_done", 32'(done), 32'(1'b0));
    check("t5_hold_diff", 32'(diff), 32'hFFFA);
    check("t5_hold_lt", 32'(a_lt_b), 32'(1'b1));

    // Reset mid-RUN aborts without a done pulse.
    launch(16'h1234, 16'h0001, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkIdle("t6_abort");
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    check("t6_no_done", 32'(sawDone), 32'(1'b0));
    launch(16'h0010, 16'h0020, 1'b0);
    waitDone(lat, busyCyc);
    check("t6_latency", 32'(lat), 32'd4);
    checkResult("t6", 1'b0, 1'b0, 1'b1, 16'hFFF0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
